// File: rtl/multi_way_signal_ctrl.sv
// Round-robin traffic-light controller for N_WAYS approaches with min/max green timing.
// Optional emergency preemption is enabled by defining EMERGENCY_PREEMPT_EN.
module multi_way_signal_ctrl #(
  parameter int unsigned N_WAYS      = 4,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned MIN_GREEN   = 2,
  parameter int unsigned MAX_GREEN   = 6,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_WAYS-1:0]         waiting,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic                      preempt,
  input  logic [$clog2(N_WAYS)-1:0] preempt_way,
`endif
  output logic [N_WAYS-1:0]         red,
  output logic [N_WAYS-1:0]         yellow,
  output logic [N_WAYS-1:0]         green,
  output logic [$clog2(N_WAYS)-1:0] active_way,
  output logic [3:0]                phase
);

  localparam int unsigned AW = $clog2(N_WAYS);

  localparam logic [CNT_W-1:0] MinG    = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] MaxG    = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] YellowT = CNT_W'(YELLOW_TIME);
  localparam logic [CNT_W-1:0] AllredT = CNT_W'(ALLRED_TIME);
  localparam logic [CNT_W-1:0] One     = CNT_W'(1);

  typedef enum logic [3:0] {
    StReset  = 4'b0001,
    StAllRed = 4'b0010,
    StGreen  = 4'b0100,
    StYellow = 4'b1000
  } phase_e;

  phase_e             phase_q, phase_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [AW-1:0]      way_q, way_d;
  logic [N_WAYS-1:0]  red_q, red_d, yellow_q, yellow_d, green_q, green_d;

  logic [N_WAYS-1:0]  way_mask;
  logic               others_wait;
  logic               leave_green;
  logic               found;
  logic [AW-1:0]      grant;
  logic [AW-1:0]      idx;

  // Round-robin scan starting just after the current way; falls back to way+1.
  always_comb begin
    grant = AW'((32'(way_q) + 32'd1) % N_WAYS);
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= N_WAYS; k++) begin
      idx = AW'((32'(way_q) + k) % N_WAYS);
      if (!found && waiting[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    way_mask        = '0;
    way_mask[way_q] = 1'b1;
    others_wait     = |(waiting & ~way_mask);
`ifdef EMERGENCY_PREEMPT_EN
    if (preempt) begin
      leave_green = (preempt_way != way_q);
    end else begin
      leave_green = (timer_q >= MinG) && others_wait && (!waiting[way_q] || timer_q >= MaxG);
    end
`else
    leave_green = (timer_q >= MinG) && others_wait && (!waiting[way_q] || timer_q >= MaxG);
`endif
  end

  always_comb begin
    phase_d = phase_q;
    timer_d = timer_q;
    way_d   = way_q;
    case (phase_q)
      StReset: begin
        phase_d = StAllRed;
        timer_d = One;
      end
      StAllRed: begin
        if (timer_q >= AllredT) begin
          phase_d = StGreen;
          timer_d = One;
`ifdef EMERGENCY_PREEMPT_EN
          way_d   = preempt ? preempt_way : grant;
`else
          way_d   = grant;
`endif
        end else begin
          timer_d = timer_q + One;
        end
      end
      StGreen: begin
        if (leave_green) begin
          phase_d = StYellow;
          timer_d = One;
        end else begin
          timer_d = (timer_q >= MaxG) ? MaxG : timer_q + One;
        end
      end
      StYellow: begin
        if (timer_q >= YellowT) begin
          phase_d = StAllRed;
          timer_d = One;
        end else begin
          timer_d = timer_q + One;
        end
      end
      default: begin
        phase_d = StAllRed;
        timer_d = One;
      end
    endcase
  end

  // Lamps are decoded from the next state so the registered lamps always match phase.
  always_comb begin
    red_d    = '1;
    yellow_d = '0;
    green_d  = '0;
    if (phase_d == StGreen) begin
      green_d[way_d] = 1'b1;
      red_d[way_d]   = 1'b0;
    end else if (phase_d == StYellow) begin
      yellow_d[way_d] = 1'b1;
      red_d[way_d]    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= StReset;
      timer_q  <= '0;
      way_q    <= AW'(N_WAYS - 1);
      red_q    <= '1;
      yellow_q <= '0;
      green_q  <= '0;
    end else begin
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      way_q    <= way_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
    end
  end

  assign red        = red_q;
  assign yellow     = yellow_q;
  assign green      = green_q;
  assign active_way = way_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_multi_way_signal_ctrl.sv
// Self-checking bench for multi_way_signal_ctrl (N_WAYS=4, default timing) against a
// cycle-level behavioural model of the phase/grant rules.
module tb_multi_way_signal_ctrl;

  localparam int N     = 4;
  localparam int MING  = 2;
  localparam int MAXG  = 6;
  localparam int YT    = 2;
  localparam int ART   = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] waiting = 4'b0000;
  logic [3:0] red, yellow, green, phase;
  logic [1:0] active_way;
`ifdef EMERGENCY_PREEMPT_EN
  logic       preempt = 1'b0;
  logic [1:0] preempt_way = 2'd0;
`endif

  int tests = 0;
  int fails = 0;

  // Model: phase 0 RESET, 1 ALL_RED, 2 GREEN, 3 YELLOW; cnt = cycles spent in phase so far.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_aw    = N - 1;

  multi_way_signal_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .waiting    (waiting),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt    (preempt),
    .preempt_way(preempt_way),
`endif
    .red        (red),
    .yellow     (yellow),
    .green      (green),
    .active_way (active_way),
    .phase      (phase)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_aw    = N - 1;
  endfunction

  function automatic void model_step(input logic [3:0] w, input bit p, input int pw);
    bit others;
    bit leave;
    bit found;
    int nxt;
    case (m_phase)
      0: begin m_phase = 1; m_cnt = 1; end
      1: begin
        if (m_cnt >= ART) begin
          if (p) begin
            nxt = pw;
          end else begin
            nxt   = (m_aw + 1) % N;
            found = 0;
            for (int k = 1; k <= N; k++) begin
              if (!found && w[(m_aw + k) % N]) begin
                found = 1;
                nxt   = (m_aw + k) % N;
              end
            end
          end
          m_aw = nxt; m_phase = 2; m_cnt = 1;
        end else begin
          m_cnt++;
        end
      end
      2: begin
        others = 0;
        for (int i = 0; i < N; i++) if (i != m_aw && w[i]) others = 1;
        if (p) leave = (pw != m_aw);
        else   leave = (m_cnt >= MING) && others && (!w[m_aw] || m_cnt == MAXG);
        if (leave) begin
          m_phase = 3; m_cnt = 1;
        end else begin
          m_cnt = (m_cnt + 1 > MAXG) ? MAXG : m_cnt + 1;
        end
      end
      default: begin
        if (m_cnt >= YT) begin m_phase = 1; m_cnt = 1; end
        else m_cnt++;
      end
    endcase
  endfunction

  function automatic logic [17:0] exp_vec();
    logic [3:0] ph, r, y, g;
    logic [1:0] aw;
    ph = 4'b0001 << m_phase;
    r  = 4'hF;
    y  = 4'h0;
    g  = 4'h0;
    aw = 2'(m_aw);
    if (m_phase == 2) begin g[aw] = 1'b1; r[aw] = 1'b0; end
    if (m_phase == 3) begin y[aw] = 1'b1; r[aw] = 1'b0; end
    return {ph, r, y, g, aw};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {phase, red, yellow, green, active_way};
  endfunction

  // Drive waiting, advance one rising edge, update the model, settle.
  task automatic tick(input logic [3:0] w);
    waiting = w;
    @(posedge clk);
    if (!rst) begin
`ifdef EMERGENCY_PREEMPT_EN
      model_step(w, preempt, int'(preempt_way));
`else
      model_step(w, 1'b0, 0);
`endif
    end
    #1;
  endtask

  task automatic do_reset(input logic [3:0] w);
    waiting = w;
    rst = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    tests++; if (phase !== 4'b0001) begin fails++; $display("FAIL reset_phase got %b want 0001", phase); end
    tests++; if (red !== 4'hF) begin fails++; $display("FAIL reset_red got %b want 1111", red); end
    tests++; if (yellow !== 4'h0) begin fails++; $display("FAIL reset_yellow got %b want 0000", yellow); end
    tests++; if (green !== 4'h0) begin fails++; $display("FAIL reset_green got %b want 0000", green); end
    tests++; if (active_way !== 2'd3) begin fails++; $display("FAIL reset_way got %0d want 3", active_way); end
    @(posedge clk); #1;
    tests++; if (phase !== 4'b0001) begin fails++; $display("FAIL reset_hold got %b want 0001", phase); end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    tick(4'b0000);
    tests++; if (phase !== 4'b0010 || red !== 4'hF) begin
      fails++; $display("FAIL idle_allred got phase %b red %b want 0010 1111", phase, red);
    end
    tick(4'b0000);
    tests++; if (phase !== 4'b0100 || green !== 4'b0001) begin
      fails++; $display("FAIL idle_first_green got phase %b green %b want 0100 0001", phase, green);
    end
    for (int i = 0; i < 15; i++) begin
      tick(4'b0000);
      tests++; if (green !== 4'b0001 || dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL idle_hold cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_min_green();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
    logic [3:0] exp_y [5] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    do_reset(4'b0000);
    tick(4'b0000);
    tick(4'b0000);
    for (int i = 0; i < 5; i++) begin
      tick(4'b0100);
      tests++; if (green !== exp_g[i] || yellow !== exp_y[i] || dut_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL min_green step %0d got g=%b y=%b (%h) want g=%b y=%b (%h)",
                 i, green, yellow, dut_vec(), exp_g[i], exp_y[i], exp_vec());
      end
    end
    tests++; if (active_way !== 2'd2) begin fails++; $display("FAIL min_green_way got %0d want 2", active_way); end
  endtask

  // Continues from way 2 green.
  task automatic test_wrap();
    bit saw_y = 0;
    bit done  = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(4'b0011);
      tests++; if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL wrap_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (yellow != 0 && !saw_y) begin
        saw_y = 1;
        tests++; if (active_way !== 2'd2) begin fails++; $display("FAIL wrap_yellow_way got %0d want 2", active_way); end
      end
      if (saw_y && green != 0) begin
        done = 1;
        tests++; if (green !== 4'b0001 || active_way !== 2'd0) begin
          fails++; $display("FAIL wrap_grant got green %b way %0d want 0001 0", green, active_way);
        end
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL wrap_timeout got no grant want grant to way 0"); end
  endtask

  task automatic test_full_load();
    int order [$];
    int lens  [$];
    int run = 0;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    do_reset(4'b1111);
    for (int i = 0; i < 80 && order.size() < 5; i++) begin
      tick(4'b1111);
      tests++; if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL full_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
      if (green != 0) begin
        if (run == 0) order.push_back(int'(active_way));
        run++;
      end else if (run != 0) begin
        lens.push_back(run);
        run = 0;
      end
    end
    tests++; if (order.size() != 5) begin
      fails++; $display("FAIL full_grants got %0d want 5", order.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        tests++; if (order[k] != exp_order[k]) begin
          fails++; $display("FAIL full_order idx %0d got %0d want %0d", k, order[k], exp_order[k]);
        end
      end
      for (int k = 0; k < lens.size(); k++) begin
        tests++; if (lens[k] != MAXG) begin
          fails++; $display("FAIL full_len idx %0d got %0d want %0d", k, lens[k], MAXG);
        end
      end
    end
  endtask

  task automatic test_async_mid_green();
    do_reset(4'b0000);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0000);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    tests++; if (red !== 4'hF || green !== 4'h0 || yellow !== 4'h0 || phase !== 4'b0001) begin
      fails++; $display("FAIL async_rst got r=%b y=%b g=%b ph=%b want 1111 0000 0000 0001",
                        red, yellow, green, phase);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    tick(4'b1111);
    tick(4'b1111);
    tests++; if (green !== 4'b0001 || active_way !== 2'd0) begin
      fails++; $display("FAIL async_first_grant got green %b way %0d want 0001 0", green, active_way);
    end
  endtask

`ifdef EMERGENCY_PREEMPT_EN
  task automatic test_preempt();
    bit done = 0;
    do_reset(4'b0010);
    tick(4'b0010);
    tick(4'b0010);
    tests++; if (green !== 4'b0010) begin fails++; $display("FAIL pre_setup got %b want 0010", green); end
    preempt = 1'b1;
    preempt_way = 2'd3;
    tick(4'b0010);
    tests++; if (yellow !== 4'b0010) begin fails++; $display("FAIL pre_yellow got %b want 0010", yellow); end
    for (int i = 0; i < 10 && !done; i++) begin
      tick(4'b0010);
      if (green != 0) begin
        done = 1;
        tests++; if (green !== 4'b1000) begin fails++; $display("FAIL pre_grant got %b want 1000", green); end
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL pre_timeout got no grant want 1000"); end
    preempt = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [3:0] w = 4'b0000;
    int nonred;
    bit bad;
    do_reset(4'b0000);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) w = 4'($urandom);
`ifdef EMERGENCY_PREEMPT_EN
      if ($urandom_range(0, 19) == 0) begin
        preempt = ~preempt;
        preempt_way = 2'($urandom);
      end
`endif
      if ($urandom_range(0, 299) == 0) begin
        do_reset(w);
      end
      tick(w);
      tests++; if (dut_vec() !== exp_vec()) begin
        fails++; $display("FAIL rand_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
      end
      nonred = 0;
      bad = 0;
      for (int k = 0; k < N; k++) begin
        if (int'(red[k]) + int'(yellow[k]) + int'(green[k]) != 1) bad = 1;
        if (!red[k]) nonred++;
      end
      tests++; if (bad || nonred > 1) begin
        fails++; $display("FAIL rand_safety cyc %0d got r=%b y=%b g=%b want one lamp each, <=1 non-red",
                          i, red, yellow, green);
      end
    end
`ifdef EMERGENCY_PREEMPT_EN
    preempt = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_idle();
    test_min_green();
    test_wrap();
    test_full_load();
    test_async_mid_green();
`ifdef EMERGENCY_PREEMPT_EN
    test_preempt();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_way_signal_ctrl.md
MULTI_WAY_SIGNAL_CTRL -- requirements
Module: multi_way_signal_ctrl

Interface
REQ-001 Parameter N_WAYS, default 4: number of approaches; legal range 2..8.
REQ-002 Parameter CNT_W, default 4: width of the phase timer.
REQ-003 Parameter MIN_GREEN, default 2: minimum green cycles; legal range 1..MAX_GREEN.
REQ-004 Parameter MAX_GREEN, default 6: green cycles after which a contested green is forced to end; legal range MIN_GREEN..2^CNT_W-1.
REQ-005 Parameter YELLOW_TIME, default 2: yellow cycles; legal range 1..2^CNT_W-1.
REQ-006 Parameter ALLRED_TIME, default 1: all-red clearance cycles; legal range 1..2^CNT_W-1.
REQ-007 clk  input  1  sole clock; all state changes on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 waiting  input  N_WAYS  bit i high = vehicles queued on approach i; sampled every clk.
REQ-010 red  output  N_WAYS  per-approach red lamp.
REQ-011 yellow  output  N_WAYS  per-approach yellow lamp.
REQ-012 green  output  N_WAYS  per-approach green lamp.
REQ-013 active_way  output  clog2(N_WAYS)  index of the approach currently (or most recently) granted.
REQ-014 phase  output  4  one-hot state: 0001 RESET, 0010 ALL_RED, 0100 GREEN, 1000 YELLOW.

Function
REQ-015 RESET -> ALL_RED on the first clk edge after rst deasserts; RESET lasts exactly 1 cycle.
REQ-016 ALL_RED: all red bits high; lasts exactly ALLRED_TIME cycles, then -> GREEN.
REQ-017 Grant on ALL_RED exit: first waiting approach scanning active_way+1, +2, ... mod N_WAYS; if none waiting, active_way+1 mod N_WAYS.
REQ-018 GREEN: green[active_way]=1, red high on all other approaches; timer is 1 in the first GREEN cycle, increments each cycle, saturates at MAX_GREEN.
REQ-019 GREEN -> YELLOW when timer>=MIN_GREEN, any other approach waiting, and (waiting[active_way]==0 or timer==MAX_GREEN); otherwise GREEN holds, indefinitely if nobody else waits.
REQ-020 YELLOW: yellow[active_way]=1, others red; lasts exactly YELLOW_TIME cycles, then -> ALL_RED; active_way unchanged.
REQ-021 Safety: at every cycle exactly one of red/yellow/green is high per approach, and at most one approach is non-red.
REQ-022 Lamp outputs and active_way are registered; they change only on clk edges or on rst assertion.
REQ-023 Illegal phase encoding recovers to ALL_RED on the next edge with all lamps red.
REQ-024 waiting changes during YELLOW or ALL_RED affect only the grant decision at ALL_RED exit.

Reset
REQ-025 rst assertion immediately (no clk edge) forces: phase=RESET, red all 1, yellow and green all 0, timer=0, active_way=N_WAYS-1, so the first grant scan starts at approach 0.
REQ-026 rst asserted in any phase aborts it; no yellow is issued.

Configuration
REQ-027 Macro EMERGENCY_PREEMPT_EN defined: adds inputs preempt (1 bit) and preempt_way (clog2(N_WAYS)).
REQ-028 With macro, preempt=1 in GREEN with active_way!=preempt_way -> YELLOW next edge, ignoring MIN_GREEN; at ALL_RED exit, preempt=1 grants preempt_way over round-robin; with preempt=1 and active_way==preempt_way, GREEN holds.
REQ-029 Without macro: ports absent; behaviour exactly REQ-015..REQ-024.

Verification (N_WAYS=4, defaults)
REQ-030 Release rst, waiting=0000 -> phase RESET 1 cycle, ALL_RED 1 cycle, then green=0001 held indefinitely.
REQ-031 Way 0 green, waiting=0100 -> green[0] exactly 2 cycles, yellow[0] 2 cycles, all red 1 cycle, then green=0100, active_way=2.
REQ-032 waiting=1111 constant -> each green lasts exactly 6 cycles; grant order 0,1,2,3,0.
REQ-033 active_way=2 in YELLOW, waiting=0011 -> next grant approach 0 (wrap-around skips 3).
REQ-034 rst asserted mid-GREEN between clk edges -> red=1111, green=0000 immediately; after release, first grant approach 0.
REQ-035 With EMERGENCY_PREEMPT_EN: way 1 green timer=1, preempt=1, preempt_way=3, waiting=0010 -> yellow[1] next cycle, then green=1000.
